// File: rtl/mips_run_ctrl.sv
// Run controller for the single-cycle MIPS core: streams a program into
// instruction memory, resets and runs the core for a bounded budget, then dumps the GPRs.
//
// state    | meaning
// ---------+--------------------------------------------------------
// IDLE     | program loaded or reset; core held in reset
// LOAD     | accepting program words into instruction memory
// RST_HOLD | core reset held for RST_CYCLES cycles after start
// RUN      | core enabled until budget exhausted or halt_in
// DUMP     | core frozen, GPRs streamed out over dump_*
// DONE     | run and dump complete; core frozen, re-run or reload allowed
module mips_run_ctrl #(
  parameter int DATA_W     = 32,
  parameter int IM_DEPTH   = 1024,
  parameter int IM_AW      = 10,
  parameter int NREG       = 32,
  parameter int RA_W       = 5,
  parameter int RST_CYCLES = 2,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              start,
  input  logic [CNT_W-1:0]  run_budget,
  input  logic              halt_in,
  output logic              im_we,
  output logic [IM_AW-1:0]  im_addr,
  output logic [DATA_W-1:0] im_wdata,
  output logic              cpu_rst,
  output logic              cpu_en,
  output logic [RA_W-1:0]   reg_raddr,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              dump_valid,
  output logic [RA_W-1:0]   dump_idx,
  output logic [DATA_W-1:0] dump_data,
  input  logic              dump_ready,
  output logic [CNT_W-1:0]  cycles_used,
  output logic              busy,
  output logic              done
);

  localparam int HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RST_HOLD, S_RUN, S_DUMP, S_DONE
  } state_t;

  state_t state, state_nx;

  logic [IM_AW:0]   wcnt;
  logic [CNT_W-1:0] budget_left;
  logic [HW-1:0]    hold_cnt;

  logic beat;
  logic start_ok;
  logic wr_full;
  logic run_last;
  logic dump_last;
  logic dump_enter;

  assign beat       = load_valid && load_ready;
  assign start_ok   = start && !beat && (state == S_IDLE || state == S_DONE);
  assign wr_full    = (wcnt >= (IM_AW+1)'(IM_DEPTH));
  assign run_last   = halt_in || (budget_left == CNT_W'(1));
  assign dump_last  = dump_valid && dump_ready && (dump_idx == RA_W'(NREG-1));
  assign dump_enter = (state != S_DUMP) && (state_nx == S_DUMP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (beat)          state_nx = load_last ? S_IDLE : S_LOAD;
        else if (start_ok) state_nx = S_RST_HOLD;
      end
      S_LOAD: begin
        // once memory is full, the producer's final (unaccepted) beat closes the load
        if (beat && load_last)                       state_nx = S_IDLE;
        else if (wr_full && load_valid && load_last) state_nx = S_IDLE;
      end
      S_RST_HOLD: begin
        if (hold_cnt == '0) state_nx = (budget_left == '0) ? S_DUMP : S_RUN;
      end
      S_RUN: begin
        if (run_last) state_nx = S_DUMP;
      end
      S_DUMP: begin
        if (dump_last) state_nx = S_DONE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    load_ready = 1'b0;
    cpu_rst    = 1'b1;
    cpu_en     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      S_IDLE: load_ready = !rst;
      S_LOAD: begin
        load_ready = !rst && !wr_full;
        busy       = 1'b1;
      end
      S_RST_HOLD: busy = 1'b1;
      S_RUN: begin
        cpu_rst = 1'b0;
        cpu_en  = 1'b1;
        busy    = 1'b1;
      end
      S_DUMP: begin
        cpu_rst = 1'b0;
        busy    = 1'b1;
      end
      S_DONE: begin
        cpu_rst    = 1'b0;
        done       = 1'b1;
        load_ready = !rst;
      end
      default: ;
    endcase
  end

  // program write port: one registered write per accepted beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt     <= '0;
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_wdata <= '0;
    end else begin
      im_we <= beat;
      if (beat) begin
        im_wdata <= load_data;
        if (state == S_LOAD) begin
          im_addr <= wcnt[IM_AW-1:0];
          wcnt    <= wcnt + (IM_AW+1)'(1);
        end else begin
          im_addr <= '0;
          wcnt    <= (IM_AW+1)'(1);
        end
      end
    end
  end

  // reset-hold and run-budget timers count down to their terminal values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      budget_left <= '0;
      hold_cnt    <= '0;
      cycles_used <= '0;
    end else begin
      if (start_ok) begin
        budget_left <= run_budget;
        hold_cnt    <= HW'(RST_CYCLES-1);
        cycles_used <= '0;
      end else if (state == S_RST_HOLD) begin
        if (hold_cnt != '0) hold_cnt <= hold_cnt - HW'(1);
      end else if (state == S_RUN) begin
        budget_left <= budget_left - CNT_W'(1);
        if (cycles_used != '1) cycles_used <= cycles_used + CNT_W'(1);
      end
    end
  end

  // reg_raddr runs one index ahead of dump_idx so accepted words stream back to back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_raddr  <= '0;
      dump_valid <= 1'b0;
      dump_idx   <= '0;
      dump_data  <= '0;
    end else if (dump_enter) begin
      reg_raddr  <= '0;
      dump_valid <= 1'b0;
    end else if (state == S_DUMP && (!dump_valid || dump_ready)) begin
      if (dump_last) begin
        dump_valid <= 1'b0;
      end else begin
        dump_valid <= 1'b1;
        dump_idx   <= reg_raddr;
        dump_data  <= reg_rdata;
        reg_raddr  <= reg_raddr + RA_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Self-checking bench for mips_run_ctrl: table-driven runs, hand-written corner
// sequences, and randomized load/run/dump checked against a transaction-level model.
module tb_mips_run_ctrl;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int NREG  = 32;
  localparam int RAW   = 5;
  localparam int RSTC  = 2;
  localparam int CW    = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           load_valid, load_last, load_ready;
  logic [DW-1:0]  load_data;
  logic           start, halt_in;
  logic [CW-1:0]  run_budget;
  logic           im_we;
  logic [AW-1:0]  im_addr;
  logic [DW-1:0]  im_wdata;
  logic           cpu_rst, cpu_en;
  logic [RAW-1:0] reg_raddr;
  logic [DW-1:0]  reg_rdata;
  logic           dump_valid, dump_ready;
  logic [RAW-1:0] dump_idx;
  logic [DW-1:0]  dump_data;
  logic [CW-1:0]  cycles_used;
  logic           busy, done;

  logic [DW-1:0]  gpr [0:NREG-1];
  logic [DW-1:0]  prog [0:15];
  logic [AW-1:0]  wq_addr [$];
  logic [DW-1:0]  wq_data [$];
  logic [RAW-1:0] cap_idx [$];
  logic [DW-1:0]  cap_data [$];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int budget;
    int halt_k;
    int rdy_mode;
    bit poke;
    int exp_used;
  } vec_t;
  vec_t tbl [8];

  assign reg_rdata = gpr[reg_raddr];

  always #5 clk = ~clk;

  mips_run_ctrl #(
    .DATA_W(DW), .IM_DEPTH(DEPTH), .IM_AW(AW), .NREG(NREG),
    .RA_W(RAW), .RST_CYCLES(RSTC), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready),
    .start(start), .run_budget(run_budget), .halt_in(halt_in),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_rst(cpu_rst), .cpu_en(cpu_en),
    .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
    .dump_valid(dump_valid), .dump_idx(dump_idx), .dump_data(dump_data),
    .dump_ready(dump_ready),
    .cycles_used(cycles_used), .busy(busy), .done(done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ctrl"}, {im_we, cpu_rst, cpu_en, load_ready, dump_valid, busy, done}, 64'b0100000);
    chk({tag, "_idx"}, {im_addr, dump_idx, reg_raddr, cycles_used}, 64'd0);
    chk({tag, "_wdata"}, im_wdata, 64'd0);
    chk({tag, "_ddata"}, dump_data, 64'd0);
  endtask

  task automatic collect_write();
    if (im_we) begin
      wq_addr.push_back(im_addr);
      wq_data.push_back(im_wdata);
    end
  endtask

  // stream prog[0..n-1]; expected: one write per word at address k with prog[k]
  task automatic load_prog(input int n, input bit gaps);
    int i, cyc;
    wq_addr.delete();
    wq_data.delete();
    i = 0;
    cyc = 0;
    while (i < n && cyc < 400) begin
      @(negedge clk);
      collect_write();
      if (gaps && $urandom_range(0, 2) == 0) begin
        load_valid = 1'b0;
      end else begin
        load_valid = 1'b1;
        load_data  = prog[i];
        load_last  = (i == n-1);
      end
      if (load_valid && load_ready) i++;
      cyc++;
    end
    @(negedge clk);
    collect_write();
    load_valid = 1'b0;
    load_last  = 1'b0;
    @(negedge clk);
    collect_write();
    chk("load_accepted", i, n);
    chk("load_wr_count", wq_addr.size(), n);
    for (int k = 0; k < n && k < wq_addr.size(); k++)
      chk("load_wr", {wq_addr[k], wq_data[k]}, {AW'(k), prog[k]});
  endtask

  // expected: RSTC reset cycles, exp_used enabled cycles, NREG words idx 0..NREG-1 = gpr[idx]
  task automatic run_prog(input int budget, input int halt_k, input int rdy_mode,
                          input bit poke, input int exp_used);
    int en, rc, cyc, viol;
    bit pend;
    logic [RAW-1:0] pidx;
    logic [DW-1:0]  pdata;
    cap_idx.delete();
    cap_data.delete();
    @(negedge clk);
    start      = 1'b1;
    run_budget = CW'(budget);
    @(negedge clk);
    start = 1'b0;
    en = 0; rc = 0; cyc = 0; viol = 0; pend = 1'b0;
    pidx = '0; pdata = '0;
    while (!done && cyc < 3000) begin
      if (cpu_rst && busy) rc++;
      if (cpu_en) en++;
      halt_in = cpu_en && (en == halt_k);
      start   = poke && cpu_en && (en == 2);
      if (pend && (!dump_valid || dump_idx !== pidx || dump_data !== pdata)) viol++;
      case (rdy_mode)
        0:       dump_ready = 1'b1;
        1:       dump_ready = (cyc % 3 == 0);
        default: dump_ready = 1'($urandom_range(0, 1));
      endcase
      if (dump_valid && dump_ready) begin
        cap_idx.push_back(dump_idx);
        cap_data.push_back(dump_data);
      end
      pend  = dump_valid && !dump_ready;
      pidx  = dump_idx;
      pdata = dump_data;
      cyc++;
      @(negedge clk);
    end
    halt_in    = 1'b0;
    start      = 1'b0;
    dump_ready = 1'b0;
    chk("run_done", done, 1);
    chk("run_busy", busy, 0);
    chk("rst_hold_cycles", rc, RSTC);
    chk("cpu_en_cycles", en, exp_used);
    chk("cycles_used", cycles_used, exp_used);
    chk("dump_stable", viol, 0);
    chk("dump_count", cap_idx.size(), NREG);
    for (int k = 0; k < cap_idx.size(); k++)
      chk("dump_word", {cap_idx[k], cap_data[k]}, {RAW'(k), gpr[k]});
    chk("done_ready", load_ready, 1);
  endtask

  initial begin
    int en, cyc, acc, n, budget, halt_k, exp_used;

    tbl[0] = '{budget: 10,  halt_k: 0, rdy_mode: 0, poke: 1'b0, exp_used: 10};
    tbl[1] = '{budget: 10,  halt_k: 0, rdy_mode: 1, poke: 1'b0, exp_used: 10};
    tbl[2] = '{budget: 100, halt_k: 6, rdy_mode: 0, poke: 1'b0, exp_used: 6};
    tbl[3] = '{budget: 0,   halt_k: 0, rdy_mode: 0, poke: 1'b0, exp_used: 0};
    tbl[4] = '{budget: 5,   halt_k: 5, rdy_mode: 2, poke: 1'b0, exp_used: 5};
    tbl[5] = '{budget: 12,  halt_k: 0, rdy_mode: 0, poke: 1'b1, exp_used: 12};
    tbl[6] = '{budget: 1,   halt_k: 0, rdy_mode: 1, poke: 1'b0, exp_used: 1};
    tbl[7] = '{budget: 3,   halt_k: 1, rdy_mode: 2, poke: 1'b0, exp_used: 1};

    for (int i = 0; i < NREG; i++) gpr[i] = 32'h1000_0000 + 32'(i) * 32'h111;
    gpr[8]  = 32'd5;
    gpr[9]  = 32'd7;
    gpr[10] = 32'd12;

    rst = 1'b1;
    load_valid = 1'b0; load_last = 1'b0; load_data = '0;
    start = 1'b0; run_budget = '0; halt_in = 1'b0; dump_ready = 1'b0;

    #2 chk_reset("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", load_ready, 1);

    prog[0] = 32'h2008_0005;
    prog[1] = 32'h2009_0007;
    prog[2] = 32'h0109_5020;
    prog[3] = 32'h0000_0000;
    load_prog(4, 1'b0);
    chk("load_idle_busy", busy, 0);
    chk("load_idle_ready", load_ready, 1);

    for (int t = 0; t < 8; t++) begin
      run_prog(tbl[t].budget, tbl[t].halt_k, tbl[t].rdy_mode, tbl[t].poke, tbl[t].exp_used);
      if (t == 0 && cap_data.size() > 10) chk("gpr10", cap_data[10], 32'h0000_000C);
    end

    // overflow: 11 beats into an 8-word memory, each presented for one cycle
    wq_addr.delete();
    wq_data.delete();
    acc = 0;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      collect_write();
      if (k == 8) chk("full_ready_low", load_ready, 0);
      load_valid = 1'b1;
      load_data  = 32'hF000_0000 + 32'(k);
      load_last  = (k == 10);
      if (load_ready) acc++;
    end
    @(negedge clk);
    collect_write();
    load_valid = 1'b0;
    load_last  = 1'b0;
    @(negedge clk);
    collect_write();
    chk("ovf_accepted", acc, DEPTH);
    chk("ovf_wr_count", wq_addr.size(), DEPTH);
    for (int k = 0; k < wq_addr.size(); k++)
      chk("ovf_wr", {wq_addr[k], wq_data[k]}, {AW'(k), 32'hF000_0000 + 32'(k)});
    chk("ovf_idle", busy, 0);

    for (int r = 0; r < 12; r++) begin
      n = $urandom_range(1, DEPTH);
      for (int k = 0; k < n; k++) prog[k] = $urandom();
      load_prog(n, 1'b1);
      for (int i = 0; i < NREG; i++) gpr[i] = $urandom();
      budget = $urandom_range(0, 30);
      halt_k = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 35);
      if (budget == 0)                         exp_used = 0;
      else if (halt_k != 0 && halt_k < budget) exp_used = halt_k;
      else                                     exp_used = budget;
      run_prog(budget, halt_k, 2, 1'b0, exp_used);
    end

    // asynchronous reset in the middle of RUN
    @(negedge clk);
    start = 1'b1;
    run_budget = 16'd50;
    @(negedge clk);
    start = 1'b0;
    en = 0;
    cyc = 0;
    while (en < 5 && cyc < 100) begin
      if (cpu_en) en++;
      cyc++;
      if (en < 5) @(negedge clk);
    end
    chk("midrun_reached", en, 5);
    #2 rst = 1'b1;
    #1 chk_reset("midrun");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrun_idle", {busy, load_ready}, 2'b01);

    // asynchronous reset in the middle of DUMP
    gpr[0] = 32'hDEAD_0001;
    dump_ready = 1'b0;
    @(negedge clk);
    start = 1'b1;
    run_budget = 16'd3;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!dump_valid && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    chk("middump_reached", {dump_valid, dump_data}, {1'b1, 32'hDEAD_0001});
    #2 rst = 1'b1;
    #1 chk_reset("middump");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("middump_idle", {busy, load_ready}, 2'b01);

    run_prog(4, 0, 0, 1'b0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_run_ctrl.md
Name: mips_run_ctrl

Overview:
Synthesizable run controller for the single-cycle MIPS core. It replaces the fixed load/reset/wait/print test sequence with a parametrised sequencer: it streams a program into instruction memory, holds the core in reset, then runs it for a programmable cycle budget or until a halt strobe. It then dumps the register file over a valid/ready stream. It sits between a host/bench stream port and the mips top (im write port, GPR read port, core reset/enable).

Parameters:
DATA_W, 32, instruction and register data width
IM_DEPTH, 1024, instruction memory depth in words
IM_AW, 10, im address width (clog2 IM_DEPTH)
NREG, 32, registers dumped (indices 0..NREG-1)
RA_W, 5, register index width
RST_CYCLES, 2, cycles cpu_rst is held after start
CNT_W, 16, width of run budget and cycle counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
load_valid  in  1  program word valid
load_data  in  DATA_W  program word
load_last  in  1  marks final program word
load_ready  out  1  controller accepts program word
start  in  1  single-cycle pulse: begin run
run_budget  in  CNT_W  max RUN cycles, sampled on accepted start
halt_in  in  1  core-side early stop (e.g. break/halt detect)
im_we  out  1  instruction memory write enable
im_addr  out  IM_AW  instruction memory word address
im_wdata  out  DATA_W  instruction memory write data
cpu_rst  out  1  core reset
cpu_en  out  1  core clock enable (PC/GPR/DM update)
reg_raddr  out  RA_W  GPR read index
reg_rdata  in  DATA_W  GPR read data (combinational)
dump_valid  out  1  dump word valid
dump_idx  out  RA_W  register index of dump word
dump_data  out  DATA_W  register value
dump_ready  in  1  consumer accepts dump word
cycles_used  out  CNT_W  RUN cycles executed in last run
busy  out  1  state not IDLE/DONE
done  out  1  run and dump complete

Behaviour:
- Reset (async, any state): state=IDLE; cpu_rst=1, cpu_en=0, im_we=0, im_addr=0, im_wdata=0, load_ready=0, dump_valid=0, dump_idx=0, dump_data=0, reg_raddr=0, cycles_used=0, busy=0, done=0. Reset mid-load/run/dump aborts, no partial outputs.
- States: IDLE, LOAD, RST_HOLD, RUN, DUMP, DONE.
- load_ready=1 in IDLE, LOAD and DONE while word count < IM_DEPTH; 0 otherwise.
- Beat accepted when load_valid&&load_ready. Next cycle: im_we=1, im_wdata=word, im_addr=write pointer; pointer increments afterwards. First beat from IDLE/DONE restarts pointer at 0, enters LOAD, clears done.
- After IM_DEPTH words, load_ready=0; excess beats are not accepted (no wrap). Accepted beat with load_last -> IDLE after its write.
- start accepted only in IDLE or DONE (re-run same program); ignored in LOAD/RST_HOLD/RUN/DUMP. Accepted start: latch run_budget, clear cycles_used and done, -> RST_HOLD.
- RST_HOLD: cpu_rst=1, cpu_en=0 for exactly RST_CYCLES cycles, then RUN.
- RUN: cpu_rst=0, cpu_en=1; cycles_used increments each RUN cycle. Leave RUN after cycle where cycles_used reaches budget, or on cycle halt_in=1 (that cycle counts; halt and budget in same cycle = one exit). Budget 0: RUN lasts 0 cycles (RST_HOLD -> DUMP directly). cycles_used saturates at 2^CNT_W-1.
- DUMP: cpu_en=0, cpu_rst=0 (state preserved). reg_raddr=i; one cycle later dump_valid=1, dump_idx=i, dump_data=reg_rdata. dump_valid, idx, data held stable until dump_ready. On handshake, i increments; next word valid the following cycle. After handshake of i=NREG-1 -> DONE.
- DONE: done=1, cpu_en=0, cpu_rst=0, busy=0; holds until start or load beat.
- busy=1 in LOAD, RST_HOLD, RUN, DUMP.

Test Plan:
- Load 4 words 0x20080005,0x20090007,0x01095020,0x00000000 (last on 4th), no backpressure -> im_we pulses at addr 0..3 with exact data; state IDLE; load_ready stays 1.
- start with run_budget=10, halt_in=0 -> cpu_rst high 2 cycles, cpu_en high exactly 10 cycles, cycles_used=10; dump yields 32 words idx 0..31, idx 10 = 0x0000000C from GPR model.
- Dump with dump_ready toggling 1-of-3 cycles -> each word held stable until accepted; no skips/duplicates; done asserted after idx 31.
- Budget 100, halt_in pulse on 6th RUN cycle -> cpu_en for 6 cycles, cycles_used=6; budget 0 -> zero RUN cycles, dump starts.
- Stream IM_DEPTH+3 words (IM_DEPTH=8) -> 8 writes addr 0..7, load_ready low after 8th, no wrap to addr 0.
- Assert rst for 1 cycle mid-RUN and mid-DUMP -> all outputs at reset values asynchronously, state IDLE; start during RUN ignored.
